// File: rtl/tteframe_enqueue_pkg.sv
// Shared definitions for the frame enqueue stage: FSM states, descriptor layout, defaults.
package tteframe_enqueue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_PAY  = 2'd2,
        ST_DESC = 2'd3
    } state_t;

    localparam int NPORT         = 4;
    localparam int DESC_MAP_HI   = 15;
    localparam int DESC_LEN_W    = 11;
    localparam int MAX_LEN_DEF   = 2047;
    localparam int BP_THRESH_DEF = 2100;

    function automatic logic [DESC_MAP_HI:0] make_desc(input logic [NPORT-1:0]      map,
                                                       input logic [DESC_LEN_W-1:0] len);
        return {map, 1'b0, len};
    endfunction

endpackage

// File: rtl/tteframe_enqueue_admit.sv
// Admission check for a new frame (combinational) and registered per-port backpressure.
module enq_admit
    import tteframe_enqueue_pkg::*;
#(
    parameter int MAX_LEN   = MAX_LEN_DEF,
    parameter int BP_THRESH = BP_THRESH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NPORT-1:0] i_map,
    input  logic [NPORT-1:0] i_pfifo_full,
    input  logic [11:0]      i_dfifo_free,
    output logic             o_acc,
    output logic [NPORT-1:0] o_bp
);

    localparam logic [11:0] W_MAX_LEN   = 12'(MAX_LEN);
    localparam logic [11:0] W_BP_THRESH = 12'(BP_THRESH);

    logic             w_low_space;
    logic [NPORT-1:0] r_bp;

    // Space is reserved for a worst-case frame since the real length is unknown up front.
    assign o_acc = (i_map != '0) &&
                   ((i_map & i_pfifo_full) == '0) &&
                   (i_dfifo_free >= W_MAX_LEN);

    assign w_low_space = (i_dfifo_free < W_BP_THRESH);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bp <= '0;
        end else begin
            r_bp <= i_pfifo_full | {NPORT{w_low_space}};
        end
    end

    assign o_bp = r_bp;

endmodule

// File: rtl/tteframe_enqueue.sv
// Frame enqueue: parses the 2-byte header, stores admitted payload in the data FIFO and
// pushes one descriptor to every destination pointer FIFO.
module tteframe_enqueue
    import tteframe_enqueue_pkg::*;
#(
    parameter int BP_THRESH = BP_THRESH_DEF,
    parameter int MAX_LEN   = MAX_LEN_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sof,
    input  logic        dv,
    input  logic [7:0]  data,
    output logic        bp0,
    output logic        bp1,
    output logic        bp2,
    output logic        bp3,
    output logic        dfifo_wr,
    output logic [7:0]  dfifo_din,
    input  logic [11:0] dfifo_free,
    output logic [3:0]  pfifo_wr,
    output logic [15:0] pfifo_din,
    input  logic [3:0]  pfifo_full,
    output logic [15:0] drop_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [DESC_LEN_W-1:0] CNT_MAX = '1;

    state_t                  r_state, w_state_nxt;
    logic [NPORT-1:0]        r_map;
    logic                    r_acc;
    logic                    r_ovf;
    logic [DESC_LEN_W-1:0]   r_cnt;
    logic                    r_dfifo_wr;
    logic [7:0]              r_dfifo_din;
    logic [NPORT-1:0]        r_pfifo_wr;
    logic [15:0]             r_pfifo_din;
    logic [15:0]             r_drop_cnt;
    logic [15:0]             r_err_cnt;

    logic                    w_acc;
    logic [NPORT-1:0]        w_bp;
    logic                    w_wr_byte;
    logic                    w_ovf_hit;
    logic                    w_desc_ok;
    logic                    w_desc_push;
    logic [1:0]              w_err_inc;

    enq_admit #(
        .MAX_LEN   (MAX_LEN),
        .BP_THRESH (BP_THRESH)
    ) u_admit (
        .clk          (clk),
        .rstn         (rstn),
        .i_map        (r_map),
        .i_pfifo_full (pfifo_full),
        .i_dfifo_free (dfifo_free),
        .o_acc        (w_acc),
        .o_bp         (w_bp)
    );

    // The header length field is ignored; the descriptor reports bytes actually stored.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_byte   = 1'b0;
        w_ovf_hit   = 1'b0;
        w_desc_ok   = r_acc && (r_cnt != '0);
        w_desc_push = 1'b0;
        w_err_inc   = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (dv && sof) w_state_nxt = ST_LEN;
            end
            ST_LEN: begin
                w_state_nxt = dv ? ST_PAY : ST_DESC;
            end
            ST_PAY: begin
                if (dv) begin
                    if (r_acc) begin
                        if (r_cnt != CNT_MAX) w_wr_byte = 1'b1;
                        else if (!r_ovf)      w_ovf_hit = 1'b1;
                    end
                    w_err_inc = {1'b0, sof} + {1'b0, w_ovf_hit};
                end else begin
                    w_state_nxt = ST_DESC;
                    w_desc_push = w_desc_ok;
                end
            end
            ST_DESC: begin
                w_state_nxt = ST_IDLE;
                w_err_inc   = {1'b0, dv && sof};
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_map       <= '0;
            r_acc       <= 1'b0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_dfifo_wr  <= 1'b0;
            r_dfifo_din <= '0;
            r_pfifo_wr  <= '0;
            r_pfifo_din <= '0;
            r_drop_cnt  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dfifo_wr <= w_wr_byte;
            r_err_cnt  <= r_err_cnt + {14'd0, w_err_inc};
            if (r_state == ST_IDLE && dv && sof) begin
                r_map <= data[3:0];
                r_acc <= 1'b0;
                r_ovf <= 1'b0;
                r_cnt <= '0;
            end
            if (r_state == ST_LEN) r_acc <= w_acc;
            if (w_wr_byte) begin
                r_dfifo_din <= data;
                r_cnt       <= r_cnt + 1'b1;
            end
            if (w_ovf_hit) r_ovf <= 1'b1;
            // Descriptor is issued on entry to DESC so it lands right after the last data write.
            if (w_desc_push) begin
                r_pfifo_wr  <= r_map;
                r_pfifo_din <= make_desc(r_map, r_cnt);
            end else begin
                r_pfifo_wr  <= '0;
            end
            if (r_state == ST_DESC && !w_desc_ok) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign {bp3, bp2, bp1, bp0} = w_bp;
    assign dfifo_wr  = r_dfifo_wr;
    assign dfifo_din = r_dfifo_din;
    assign pfifo_wr  = r_pfifo_wr;
    assign pfifo_din = r_pfifo_din;
    assign drop_cnt  = r_drop_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_tteframe_enqueue.sv
// Directed bench for tteframe_enqueue with hand-computed expectations.
module tb_tteframe_enqueue;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sof = 1'b0;
    logic        dv = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [11:0] dfifo_free = 12'd4095;
    logic [3:0]  pfifo_full = 4'h0;
    logic        bp0, bp1, bp2, bp3;
    logic        dfifo_wr;
    logic [7:0]  dfifo_din;
    logic [3:0]  pfifo_wr;
    logic [15:0] pfifo_din;
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;

    tteframe_enqueue dut (
        .clk        (clk),
        .rstn       (rstn),
        .sof        (sof),
        .dv         (dv),
        .data       (data),
        .bp0        (bp0),
        .bp1        (bp1),
        .bp2        (bp2),
        .bp3        (bp3),
        .dfifo_wr   (dfifo_wr),
        .dfifo_din  (dfifo_din),
        .dfifo_free (dfifo_free),
        .pfifo_wr   (pfifo_wr),
        .pfifo_din  (pfifo_din),
        .pfifo_full (pfifo_full),
        .drop_cnt   (drop_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    int          mon_wr = 0;
    int          mon_sum = 0;
    int          mon_pf = 0;
    logic [3:0]  pf_last_wr = 4'h0;
    logic [15:0] pf_last_din = 16'h0;

    always @(negedge clk) begin
        if (dfifo_wr) begin
            mon_wr  <= mon_wr + 1;
            mon_sum <= mon_sum + int'(dfifo_din);
        end
        if (pfifo_wr != 4'h0) begin
            mon_pf      <= mon_pf + 1;
            pf_last_wr  <= pfifo_wr;
            pf_last_din <= pfifo_din;
        end
    end

    int b_wr, b_sum, b_pf;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap;
        b_wr  = mon_wr;
        b_sum = mon_sum;
        b_pf  = mon_pf;
    endtask

    function automatic int exp_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += (i & 255);
        return s;
    endfunction

    // Header bytes, then n payload bytes (value i&255); sof re-asserted on payload index stray.
    task automatic send_body(input logic [7:0] b0, input logic [7:0] b1, input int n, input int stray);
        tick; sof = 1'b1; dv = 1'b1; data = b0;
        tick; sof = 1'b0; data = b1;
        for (int i = 0; i < n; i++) begin
            tick;
            data = 8'(i);
            sof  = (i == stray);
        end
    endtask

    task automatic end_frame;
        tick; dv = 1'b0; sof = 1'b0; data = 8'h00;
        repeat (4) tick;
    endtask

    initial begin
        #12;
        chk("rst_dfifo_wr", {31'd0, dfifo_wr}, 32'd0);
        chk("rst_pfifo_wr", {28'd0, pfifo_wr}, 32'd0);
        chk("rst_bp", {28'd0, bp3, bp2, bp1, bp0}, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
        chk("rst_err", {16'd0, err_cnt}, 32'd0);
        tick; rstn = 1'b1;
        repeat (2) tick;

        // Unicast 64 bytes with exact descriptor timing
        snap;
        send_body(8'h01, 8'h40, 64, -1);
        tick; dv = 1'b0; data = 8'h00;
        @(negedge clk);
        chk("uc_last_wr", {31'd0, dfifo_wr}, 32'd1);
        chk("uc_last_din", {24'd0, dfifo_din}, 32'h3F);
        chk("uc_pf_early", {28'd0, pfifo_wr}, 32'd0);
        tick; @(negedge clk);
        chk("uc_pf_wr", {28'd0, pfifo_wr}, 32'h1);
        chk("uc_pf_din", {16'd0, pfifo_din}, 32'h1040);
        tick; @(negedge clk);
        chk("uc_pf_one", {28'd0, pfifo_wr}, 32'd0);
        repeat (3) tick;
        chk("uc_nwr", mon_wr - b_wr, 32'd64);
        chk("uc_sum", mon_sum - b_sum, exp_sum(64));
        chk("uc_npf", mon_pf - b_pf, 32'd1);
        chk("uc_drop", {16'd0, drop_cnt}, 32'd0);

        // Multicast map 1011, 100 bytes
        snap;
        send_body(8'h0B, 8'h64, 100, -1);
        end_frame;
        chk("mc_nwr", mon_wr - b_wr, 32'd100);
        chk("mc_sum", mon_sum - b_sum, exp_sum(100));
        chk("mc_npf", mon_pf - b_pf, 32'd1);
        chk("mc_pf_wr", {28'd0, pf_last_wr}, 32'hB);
        chk("mc_pf_din", {16'd0, pf_last_din}, 32'hB064);

        // Pointer FIFO full on a destination port
        pfifo_full = 4'b0010;
        @(negedge clk);
        chk("bp1_lag", {28'd0, bp3, bp2, bp1, bp0}, 32'h0);
        tick; @(negedge clk);
        chk("bp1_set", {28'd0, bp3, bp2, bp1, bp0}, 32'h2);
        snap;
        send_body(8'h03, 8'h0A, 10, -1);
        end_frame;
        chk("full_nwr", mon_wr - b_wr, 32'd0);
        chk("full_npf", mon_pf - b_pf, 32'd0);
        chk("full_drop", {16'd0, drop_cnt}, 32'd1);
        pfifo_full = 4'h0;

        // Data FIFO space boundaries
        dfifo_free = 12'd2000;
        snap;
        send_body(8'h01, 8'h05, 5, -1);
        end_frame;
        chk("free2000_nwr", mon_wr - b_wr, 32'd0);
        chk("free2000_drop", {16'd0, drop_cnt}, 32'd2);
        chk("free2000_bp", {28'd0, bp3, bp2, bp1, bp0}, 32'hF);
        dfifo_free = 12'd2047;
        snap;
        send_body(8'h01, 8'h05, 5, -1);
        end_frame;
        chk("free2047_nwr", mon_wr - b_wr, 32'd5);
        chk("free2047_pf_din", {16'd0, pf_last_din}, 32'h1005);
        chk("free2047_drop", {16'd0, drop_cnt}, 32'd2);
        dfifo_free = 12'd2099;
        tick; @(negedge clk);
        chk("free2099_bp", {28'd0, bp3, bp2, bp1, bp0}, 32'hF);
        dfifo_free = 12'd2100;
        tick; @(negedge clk);
        chk("free2100_bp", {28'd0, bp3, bp2, bp1, bp0}, 32'h0);
        dfifo_free = 12'd4095;
        tick;

        // Oversize 2100-byte frame
        snap;
        send_body(8'h84, 8'h34, 2100, -1);
        end_frame;
        chk("ovf_nwr", mon_wr - b_wr, 32'd2047);
        chk("ovf_sum", mon_sum - b_sum, exp_sum(2047));
        chk("ovf_pf_din", {16'd0, pf_last_din}, 32'h47FF);
        chk("ovf_err", {16'd0, err_cnt}, 32'd1);

        // Stray sof inside payload
        snap;
        send_body(8'h02, 8'h0A, 10, 3);
        end_frame;
        chk("stray_nwr", mon_wr - b_wr, 32'd10);
        chk("stray_pf_din", {16'd0, pf_last_din}, 32'h200A);
        chk("stray_err", {16'd0, err_cnt}, 32'd2);

        // Header-only frame
        snap;
        send_body(8'h01, 8'h00, 0, -1);
        end_frame;
        chk("hdr_nwr", mon_wr - b_wr, 32'd0);
        chk("hdr_npf", mon_pf - b_pf, 32'd0);
        chk("hdr_drop", {16'd0, drop_cnt}, 32'd3);

        // sof landing in the DESC cycle is lost
        snap;
        send_body(8'h01, 8'h02, 2, -1);
        tick; dv = 1'b0; data = 8'h00;
        tick; dv = 1'b1; sof = 1'b1; data = 8'h01;
        tick; dv = 1'b0; sof = 1'b0; data = 8'h00;
        repeat (4) tick;
        chk("desc_sof_nwr", mon_wr - b_wr, 32'd2);
        chk("desc_sof_npf", mon_pf - b_pf, 32'd1);
        chk("desc_sof_err", {16'd0, err_cnt}, 32'd3);
        chk("desc_sof_drop", {16'd0, drop_cnt}, 32'd3);

        // Reset in the middle of payload
        send_body(8'h01, 8'h14, 20, -1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_dwr", {31'd0, dfifo_wr}, 32'd0);
        chk("mid_rst_pwr", {28'd0, pfifo_wr}, 32'd0);
        chk("mid_rst_cnts", {drop_cnt, err_cnt}, 32'd0);
        dv = 1'b0; sof = 1'b0; data = 8'h00;
        tick; rstn = 1'b1;
        repeat (2) tick;
        snap;
        send_body(8'h08, 8'h03, 3, -1);
        end_frame;
        chk("post_rst_nwr", mon_wr - b_wr, 32'd3);
        chk("post_rst_npf", mon_pf - b_pf, 32'd1);
        chk("post_rst_pf_wr", {28'd0, pf_last_wr}, 32'h8);
        chk("post_rst_pf_din", {16'd0, pf_last_din}, 32'h8003);
        chk("post_rst_drop", {16'd0, drop_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
